// File: rtl/instr_isa_pkg.sv
// Shared ISA definitions for the instruction memory loader: field widths,
// opcode constants, loader states and the decoded field bundle.
package instr_isa_pkg;

  localparam int unsigned OPC_W  = 2;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned JOFF_W = 6;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned PAGE_W = WORD_W - JOFF_W;

  localparam logic [OPC_W-1:0] OP_0   = 2'b00;
  localparam logic [OPC_W-1:0] OP_1   = 2'b01;
  localparam logic [OPC_W-1:0] OP_2   = 2'b10;
  localparam logic [OPC_W-1:0] OP_JMP = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    VREAD,
    VCMP,
    DONE
  } state_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rdest;
    logic [REG_W-1:0]  rsrc;
    logic [WORD_W-1:0] jump_target;
  } instr_fields_t;

endpackage

// File: rtl/instr_encoder.sv
// Packs decoded fields into an 8-bit instruction word and checks that a jump
// target lies in the page fetch will rebuild it from ({pc[7:6], instr[5:0]}).
module instr_encoder
  import instr_isa_pkg::*;
(
  input  instr_fields_t     fields,
  input  logic [PAGE_W-1:0] page,
  output logic [WORD_W-1:0] word,
  output logic              page_ok
);

  always_comb begin
    word    = {fields.opcode, fields.rdest, fields.rsrc};
    page_ok = 1'b1;
    if (fields.opcode == OP_JMP) begin
      word    = {OP_JMP, fields.jump_target[JOFF_W-1:0]};
      page_ok = (fields.jump_target[WORD_W-1:JOFF_W] == page);
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Sequential program loader for the instruction memory write port.
// Optional read-back check of every written word: INSTR_LOADER_VERIFY_EN.
module instr_mem_loader
  import instr_isa_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_W-1:0]  in_rdest,
  input  logic [REG_W-1:0]  in_rsrc,
  input  logic [WORD_W-1:0] in_jump_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [AW-1:0]     mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_page,
  output logic              err_full,
  output logic [AW-1:0]     words_written
`ifdef INSTR_LOADER_VERIFY_EN
  ,
  output logic [AW-1:0]     mem_raddr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              err_verify
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic                last_q, last_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [AW-1:0]       mem_waddr_q, mem_waddr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_page_q, err_page_d;
  logic                err_full_q, err_full_d;
  logic [AW-1:0]       words_q, words_d;
`ifdef INSTR_LOADER_VERIFY_EN
  logic [AW-1:0]       mem_raddr_q, mem_raddr_d;
  logic                err_verify_q, err_verify_d;
`endif

  instr_fields_t       fields;
  logic [WORD_W-1:0]   enc_word;
  logic                enc_page_ok;

  assign fields = '{opcode: in_opcode, rdest: in_rdest, rsrc: in_rsrc,
                    jump_target: in_jump_target};

  instr_encoder u_encoder (
    .fields  (fields),
    .page    (ptr_q[AW-1:AW-PAGE_W]),
    .word    (enc_word),
    .page_ok (enc_page_ok)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    busy_d       = busy_q;
    err_page_d   = err_page_q;
    err_full_d   = err_full_q;
    words_d      = words_q;
`ifdef INSTR_LOADER_VERIFY_EN
    mem_raddr_d  = mem_raddr_q;
    err_verify_d = err_verify_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d      = base_addr;
          err_page_d = 1'b0;
          err_full_d = 1'b0;
          words_d    = '0;
          busy_d     = 1'b1;
`ifdef INSTR_LOADER_VERIFY_EN
          err_verify_d = 1'b0;
`endif
          if ({1'b0, base_addr} >= DEPTH_X) begin
            err_full_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      ACCEPT: begin
        if (in_valid && in_ready_q) begin
          last_d = in_last;
          if (!enc_page_ok) begin
            err_page_d = 1'b1;
            state_d    = DONE;
          end else begin
            mem_waddr_d = ptr_q;
            mem_wdata_d = enc_word;
            state_d     = WRITE;
          end
        end
      end
      WRITE: begin
        words_d = words_q + AW'(1);
`ifdef INSTR_LOADER_VERIFY_EN
        mem_raddr_d = ptr_q;
        state_d     = VREAD;
`else
        if (last_q) begin
          state_d = DONE;
        end else if (ptr_q == LAST_ADDR) begin
          err_full_d = 1'b1;
          state_d    = DONE;
        end else begin
          ptr_d   = ptr_q + AW'(1);
          state_d = ACCEPT;
        end
`endif
      end
`ifdef INSTR_LOADER_VERIFY_EN
      VREAD: state_d = VCMP;
      VCMP: begin
        if (mem_rdata != mem_wdata_q) begin
          err_verify_d = 1'b1;
          state_d      = DONE;
        end else if (last_q) begin
          state_d = DONE;
        end else if (ptr_q == LAST_ADDR) begin
          err_full_d = 1'b1;
          state_d    = DONE;
        end else begin
          ptr_d   = ptr_q + AW'(1);
          state_d = ACCEPT;
        end
      end
`endif
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they line up with it
    in_ready_d = (state_d == ACCEPT);
    mem_we_d   = (state_d == WRITE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_page_q   <= 1'b0;
      err_full_q   <= 1'b0;
      words_q      <= '0;
`ifdef INSTR_LOADER_VERIFY_EN
      mem_raddr_q  <= '0;
      err_verify_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_page_q   <= err_page_d;
      err_full_q   <= err_full_d;
      words_q      <= words_d;
`ifdef INSTR_LOADER_VERIFY_EN
      mem_raddr_q  <= mem_raddr_d;
      err_verify_q <= err_verify_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_waddr     = mem_waddr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_page      = err_page_q;
  assign err_full      = err_full_q;
  assign words_written = words_q;
`ifdef INSTR_LOADER_VERIFY_EN
  assign mem_raddr     = mem_raddr_q;
  assign err_verify    = err_verify_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: random and directed loads checked
// against an address/word reference model; covers INSTR_LOADER_VERIFY_EN too.
module tb_instr_mem_loader;

  localparam int DEPTH = 96;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_opcode = '0;
  logic [2:0] in_rdest = '0;
  logic [2:0] in_rsrc = '0;
  logic [7:0] in_jump_target = '0;
  logic       in_last = 1'b0;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic       err_page;
  logic       err_full;
  logic [7:0] words_written;
`ifdef INSTR_LOADER_VERIFY_EN
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       err_verify;
  logic [7:0] mem [256];
  bit         corrupt_a2 = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(DEPTH), .AW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rdest(in_rdest), .in_rsrc(in_rsrc), .in_jump_target(in_jump_target),
    .in_last(in_last), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err_page(err_page),
    .err_full(err_full), .words_written(words_written)
`ifdef INSTR_LOADER_VERIFY_EN
    , .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .err_verify(err_verify)
`endif
  );

`ifdef INSTR_LOADER_VERIFY_EN
  // Synchronous memory with an optional stuck value at address 2
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= (corrupt_a2 && mem_waddr == 8'd2) ? 8'hFF : mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end
`endif

  typedef struct {
    int op; int rd; int rs; int jt; bit last;
  } bun_t;
  typedef struct { int addr; int data; } wr_t;
  typedef struct { int words; bit ep; bit ef; bit ev; } fin_t;

  bun_t prog[$];
  wr_t  exp_w[$];
  fin_t exp_f[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference model: walk the program from base, producing writes and the final status
  function automatic void model(input int base, input bit corrupt);
    fin_t f;
    int   addr;
    int   w;
    f = '{0, 1'b0, 1'b0, 1'b0};
    addr = base;
    if (base >= DEPTH) f.ef = 1'b1;
    else begin
      for (int i = 0; i < prog.size(); i++) begin
        if (prog[i].op == 3) begin
          if (prog[i].jt / 64 != addr / 64) begin f.ep = 1'b1; break; end
          w = 192 + prog[i].jt % 64;
        end else begin
          w = prog[i].op * 64 + prog[i].rd * 8 + prog[i].rs;
        end
        exp_w.push_back('{addr, w});
        f.words++;
        if (corrupt && addr == 2 && w != 255) begin f.ev = 1'b1; break; end
        if (prog[i].last) break;
        if (addr == DEPTH - 1) begin f.ef = 1'b1; break; end
        addr++;
      end
    end
    exp_f.push_back(f);
  endfunction

  // Monitor: every write and every done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        if (exp_w.size() == 0) fail_now("unexpected_mem_we");
        else begin
          wr_t e;
          e = exp_w.pop_front();
          chk("waddr", int'(mem_waddr), e.addr);
          chk("wdata", int'(mem_wdata), e.data);
        end
      end
      if (done) begin
        if (exp_f.size() == 0) fail_now("unexpected_done");
        else begin
          fin_t f;
          f = exp_f.pop_front();
          chk("words_written", int'(words_written), f.words);
          chk("err_page", int'(err_page), int'(f.ep));
          chk("err_full", int'(err_full), int'(f.ef));
          chk("busy_at_done", int'(busy), 1);
`ifdef INSTR_LOADER_VERIFY_EN
          chk("err_verify", int'(err_verify), int'(f.ev));
`endif
        end
      end
    end
  end

  function automatic bun_t rand_bun(input int page);
    bun_t b;
    b.op = int'($urandom_range(0, 3));
    b.rd = int'($urandom_range(0, 7));
    b.rs = int'($urandom_range(0, 7));
    b.jt = int'($urandom_range(0, 255));
    if (b.op == 3 && $urandom_range(0, 4) != 0) b.jt = (page % 4) * 64 + int'($urandom_range(0, 63));
    b.last = 1'b0;
    return b;
  endfunction

  task automatic start_load(input int b);
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'(b);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one bundle until taken or the load has ended; optional stray start pulse
  task automatic send(input bun_t b, input bit hold, input bit glitch, output bit acc);
    bit ended;
    acc = 1'b0;
    ended = 1'b0;
    in_opcode = 2'(b.op);
    in_rdest = 3'(b.rd);
    in_rsrc = 3'(b.rs);
    in_jump_target = 8'(b.jt);
    in_last = b.last;
    in_valid = 1'b1;
    if (glitch) begin
      start = 1'b1;
      base_addr = 8'($urandom_range(0, 255));
    end
    for (int c = 0; c < 50; c++) begin
      if (in_ready) begin
        acc = 1'b1;
        @(negedge clk);
        start = 1'b0;
        break;
      end
      if (done || !busy) begin
        ended = 1'b1;
        chk("ready_after_end", int'(in_ready), 0);
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    if (!acc && !ended) fail_now("accept_timeout");
    if (!hold || !acc) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    if (busy) fail_now("busy_timeout");
    in_valid = 1'b0;
  endtask

  task automatic run_load(input int base, input bit hold, input int glitch_at, input bit corrupt);
    bit acc;
    model(base, corrupt);
    start_load(base);
    if (base < DEPTH) begin
      for (int i = 0; i < prog.size(); i++) begin
        send(prog[i], hold, i == glitch_at, acc);
        if (!acc) break;
        if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    wait_idle();
  endtask

  function automatic bun_t mk(input int op, input int rd, input int rs, input int jt, input bit last);
    bun_t b;
    b.op = op; b.rd = rd; b.rs = rs; b.jt = jt; b.last = last;
    return b;
  endfunction

  initial begin
    bit acc;
    int base;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err_page", int'(err_page), 0);
    chk("rst_err_full", int'(err_full), 0);
    chk("rst_mem_waddr", int'(mem_waddr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_words", int'(words_written), 0);
    reset = 1'b0;
    @(negedge clk);

    // Reference program from base 0
    prog = {};
    prog.push_back(mk(0, 1, 0, 0, 0));
    prog.push_back(mk(1, 1, 3, 0, 0));
    prog.push_back(mk(1, 0, 2, 0, 0));
    prog.push_back(mk(3, 0, 0, 8'h05, 0));
    prog.push_back(mk(0, 0, 0, 0, 0));
    prog.push_back(mk(1, 0, 5, 0, 1));
    run_load(0, 1'b0, -1, 1'b0);

    // Jump into the wrong page
    prog = {};
    prog.push_back(mk(3, 2, 2, 8'h05, 1));
    run_load(8'h40, 1'b0, -1, 1'b0);

    // Run off the end of memory
    prog = {};
    for (int i = 0; i < 3; i++) prog.push_back(mk(2, i, i + 1, 0, 0));
    run_load(DEPTH - 2, 1'b0, -1, 1'b0);

    // Base outside memory
    prog = {};
    run_load(DEPTH, 1'b0, -1, 1'b0);
    run_load(200, 1'b0, -1, 1'b0);

    // Valid held high, stray start mid-load
    prog = {};
    for (int i = 0; i < 5; i++) prog.push_back(rand_bun(0));
    for (int i = 0; i < 5; i++) if (prog[i].op == 3) prog[i].jt = prog[i].jt % 64;
    prog[4].last = 1'b1;
    run_load(3, 1'b1, 2, 1'b0);

    // Reset in the cycle after the second write
    prog = {};
    for (int i = 0; i < 4; i++) prog.push_back(mk(int'($urandom_range(0, 2)), i, 7 - i, 0, i == 3));
    model(0, 1'b0);
    exp_w.pop_back();
    exp_w.pop_back();
    void'(exp_f.pop_back());
    start_load(0);
    send(prog[0], 1'b0, 1'b0, acc);
    send(prog[1], 1'b0, 1'b0, acc);
    in_opcode = 2'(prog[2].op);
    in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_mem_we", int'(mem_we), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_words", int'(words_written), 0);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    prog = {};
    for (int i = 0; i < 4; i++) prog.push_back(rand_bun(0));
    prog[3].last = 1'b1;
    run_load(0, 1'b0, -1, 1'b0);

`ifdef INSTR_LOADER_VERIFY_EN
    corrupt_a2 = 1'b1;
    prog = {};
    for (int i = 0; i < 5; i++) prog.push_back(mk(int'($urandom_range(0, 2)), i, i, 0, i == 4));
    run_load(0, 1'b0, -1, 1'b1);
    corrupt_a2 = 1'b0;
`endif

    // Random loads
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: base = int'($urandom_range(0, 15));
        3, 4:    base = DEPTH - int'($urandom_range(1, 5));
        5, 6:    base = int'($urandom_range(64, DEPTH - 1));
        default: base = int'($urandom_range(DEPTH, 255));
      endcase
      n = int'($urandom_range(1, 8));
      prog = {};
      for (int i = 0; i < n; i++) begin
        prog.push_back(rand_bun(base / 64));
        if ($urandom_range(0, 9) == 0) prog[i].last = 1'b1;
      end
      prog[n - 1].last = 1'b1;
      run_load(base, $urandom_range(0, 1) == 1, int'($urandom_range(0, 9)), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("writes_outstanding", exp_w.size(), 0);
    chk("dones_outstanding", exp_f.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
